// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, widths and decode helpers
package mips_pkg;

  localparam int XLEN    = 32;
  localparam int OP_W    = 6;
  localparam int FN_W    = 6;
  localparam int SHAMT_W = 5;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [OP_W-1:0] opcode_t;
  typedef logic [FN_W-1:0] funct_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam funct_t  FN_JR    = 6'h08;

  function automatic word_t sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch/decode bundle: instruction in, next-PC selection out
interface decode_if;
  import mips_pkg::*;

  word_t instr_f;
  word_t pc_plus_4_f;
  logic  stall_d;
  logic  flush_d;
  logic  branch;
  logic  jump;
  logic  jump_reg;
  word_t branch_addr;
  word_t jump_addr;
  word_t jump_reg_addr;

  modport master (
    output instr_f, pc_plus_4_f, stall_d, flush_d,
    input  branch, jump, jump_reg, branch_addr, jump_addr, jump_reg_addr
  );

  modport slave (
    input  instr_f, pc_plus_4_f, stall_d, flush_d,
    output branch, jump, jump_reg, branch_addr, jump_addr, jump_reg_addr
  );
endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2-read/1-write register file, entry 0 hardwired to zero
// RF_WRITE_THROUGH_EN: forward the in-flight writeback to matching reads.
module regfile
  import mips_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RF_AW-1:0] ra1,
  input  logic [RF_AW-1:0] ra2,
  output word_t            rd1,
  output word_t            rd2,
  input  logic             we,
  input  logic [RF_AW-1:0] wa,
  input  word_t            wd
);

  logic [2**RF_AW-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

`ifdef RF_WRITE_THROUGH_EN
  logic wr_fwd;
  assign wr_fwd = we && (wa != '0) && !reset;
`endif

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef RF_WRITE_THROUGH_EN
    if (wr_fwd && (wa == ra1)) rd1 = wd;
    if (wr_fwd && (wa == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - IF/ID register, field decode, branch compare and next-PC candidates
// Optional RF_WRITE_THROUGH_EN selects register-file write-through reads.
module decode
  import mips_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  decode_if.slave          fd,
  input  logic             reg_write_w,
  input  logic [RF_AW-1:0] write_reg_w,
  input  word_t            result_w,
  input  logic             forward_a_d,
  input  logic             forward_b_d,
  input  word_t            alu_out_m,
  output word_t            rd1_d,
  output word_t            rd2_d,
  output logic [RF_AW-1:0] rs_d,
  output logic [RF_AW-1:0] rt_d,
  output logic [RF_AW-1:0] rd_d,
  output logic [SHAMT_W-1:0] shamt_d,
  output opcode_t          op_d,
  output funct_t           funct_d,
  output word_t            sign_imm_d,
  output word_t            pc_plus_4_d
);

  word_t instr_d;
  word_t cmp_a;
  word_t cmp_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d     <= '0;
      pc_plus_4_d <= '0;
    end else if (fd.flush_d) begin
      instr_d     <= '0;
      pc_plus_4_d <= '0;
    end else if (!fd.stall_d) begin
      instr_d     <= fd.instr_f;
      pc_plus_4_d <= fd.pc_plus_4_f;
    end
  end

  assign op_d       = instr_d[31:26];
  assign rs_d       = RF_AW'(instr_d[25:21]);
  assign rt_d       = RF_AW'(instr_d[20:16]);
  assign rd_d       = RF_AW'(instr_d[15:11]);
  assign shamt_d    = instr_d[10:6];
  assign funct_d    = instr_d[5:0];
  assign sign_imm_d = sext16(instr_d[15:0]);

  regfile #(.RF_AW(RF_AW)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs_d),
    .ra2   (rt_d),
    .rd1   (rd1_d),
    .rd2   (rd2_d),
    .we    (reg_write_w),
    .wa    (write_reg_w),
    .wd    (result_w)
  );

  // Forwarding is masked in reset so every output reads zero while it is held.
  assign cmp_a = (forward_a_d && !reset) ? alu_out_m : rd1_d;
  assign cmp_b = (forward_b_d && !reset) ? alu_out_m : rd2_d;

  assign fd.branch_addr   = pc_plus_4_d + {sign_imm_d[29:0], 2'b00};
  assign fd.jump_addr     = {pc_plus_4_d[31:28], instr_d[25:0], 2'b00};
  assign fd.jump_reg_addr = cmp_a;

  assign fd.branch   = ((op_d == OP_BEQ) && (cmp_a == cmp_b)) ||
                       ((op_d == OP_BNE) && (cmp_a != cmp_b));
  assign fd.jump     = (op_d == OP_J) || (op_d == OP_JAL);
  assign fd.jump_reg = (op_d == OP_RTYPE) && (funct_d == FN_JR);

endmodule
